// File: rtl/s2mm_st_packetizer.sv
// Frames a 32-bit word stream (upstream or internal counter) into fixed-length
// Avalon-ST packets with SOP/EOP for the mSGDMA S2MM sink; counts finished packets.
module s2mm_st_packetizer #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cfg_enable,
   input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
   input  logic                  cfg_pattern,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   output logic [DATA_WIDTH-1:0] src_data,
   output logic                  src_valid,
   input  logic                  src_ready,
   output logic                  src_startofpacket,
   output logic                  src_endofpacket,
   output logic [31:0]           pkt_count,
   output logic                  busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic                  mode_q, mode_d;
   logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
   logic [31:0]           pat_q, pat_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  sop_q, sop_d;
   logic                  eop_q, eop_d;
   logic [31:0]           pkt_q, pkt_d;

   logic load_ok;
   logic start_ok;
   logic in_run;
   logic produce;
   logic last_beat;
   logic accept_eop;

   assign load_ok    = ~valid_q | src_ready;
   assign start_ok   = cfg_enable & (cfg_pkt_len != '0);
   assign in_run     = (state_q == ST_RUN);
   // Pattern mode always has a word ready; forward mode waits on upstream.
   assign produce    = in_run & load_ok & (mode_q | s_tvalid);
   assign last_beat  = (beat_cnt_q == (len_q - LEN_WIDTH'(1)));
   assign accept_eop = valid_q & src_ready & eop_q;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      mode_d     = mode_q;
      beat_cnt_d = beat_cnt_q;
      pat_d      = pat_q;
      data_d     = data_q;
      valid_d    = valid_q;
      sop_d      = sop_q;
      eop_d      = eop_q;
      pkt_d      = pkt_q;

      if (load_ok) begin
         valid_d = 1'b0;
         sop_d   = 1'b0;
         eop_d   = 1'b0;
      end

      if (accept_eop) begin
         pkt_d = pkt_q + 32'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d    = ST_RUN;
               len_d      = cfg_pkt_len;
               mode_d     = cfg_pattern;
               beat_cnt_d = '0;
            end
         end
         ST_RUN: begin
            if (produce) begin
               valid_d = 1'b1;
               data_d  = mode_q ? DATA_WIDTH'(pat_q) : s_tdata;
               sop_d   = (beat_cnt_q == '0);
               eop_d   = last_beat;
               if (mode_q) begin
                  pat_d = pat_q + 32'd1;
               end
               if (last_beat) begin
                  beat_cnt_d = '0;
                  // Back-to-back packets re-sample the configuration at the boundary.
                  if (start_ok) begin
                     len_d  = cfg_pkt_len;
                     mode_d = cfg_pattern;
                  end else begin
                     state_d = ST_FLUSH;
                  end
               end else begin
                  beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
               end
            end
         end
         ST_FLUSH: begin
            if (accept_eop) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         mode_q     <= 1'b0;
         beat_cnt_q <= '0;
         pat_q      <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         sop_q      <= 1'b0;
         eop_q      <= 1'b0;
         pkt_q      <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         mode_q     <= mode_d;
         beat_cnt_q <= beat_cnt_d;
         pat_q      <= pat_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         sop_q      <= sop_d;
         eop_q      <= eop_d;
         pkt_q      <= pkt_d;
      end
   end

   assign s_tready          = load_ok & in_run & ~mode_q;
   assign src_data          = data_q;
   assign src_valid         = valid_q;
   assign src_startofpacket = sop_q;
   assign src_endofpacket   = eop_q;
   assign pkt_count         = pkt_q;
   assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_s2mm_st_packetizer.sv
// Randomized bench for s2mm_st_packetizer: a negedge monitor collects accepted
// beats, and each scenario compares them against packets rebuilt from the stimulus.
module tb_s2mm_st_packetizer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cfg_enable = 1'b0;
   logic [15:0] cfg_pkt_len = '0;
   logic        cfg_pattern = 1'b0;
   logic [31:0] s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic [31:0] src_data;
   logic        src_valid;
   logic        src_ready = 1'b0;
   logic        src_startofpacket;
   logic        src_endofpacket;
   logic [31:0] pkt_count;
   logic        busy;

   always #5 clk = ~clk;

   s2mm_st_packetizer #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .cfg_enable(cfg_enable), .cfg_pkt_len(cfg_pkt_len), .cfg_pattern(cfg_pattern),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
      .src_startofpacket(src_startofpacket), .src_endofpacket(src_endofpacket),
      .pkt_count(pkt_count), .busy(busy)
   );

   typedef struct packed {
      logic [31:0] data;
      logic        sop;
      logic        eop;
   } beat_t;

   beat_t       out_q[$];
   logic [31:0] in_q[$];
   logic [31:0] stim[$];
   int          vectors = 0;
   int          errors = 0;
   int          cyc = 0;
   int          first_fire = -1;
   int          last_fire = -1;
   bit          saw_tready = 1'b0;
   bit          prev_stall = 1'b0;
   beat_t       prev_beat;

   // Monitor: handshakes are stable at the falling edge and complete on the next rising edge.
   always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            vectors++;
            if (src_valid !== 1'b1 || src_data !== prev_beat.data ||
                src_startofpacket !== prev_beat.sop || src_endofpacket !== prev_beat.eop) begin
               errors++;
               $display("FAIL stall_hold: got v=%b d=%h sop=%b eop=%b, required v=1 d=%h sop=%b eop=%b",
                        src_valid, src_data, src_startofpacket, src_endofpacket,
                        prev_beat.data, prev_beat.sop, prev_beat.eop);
            end
         end
         prev_stall = src_valid & ~src_ready;
         prev_beat  = {src_data, src_startofpacket, src_endofpacket};
         if (s_tready) saw_tready = 1'b1;
         if (s_tvalid & s_tready) in_q.push_back(s_tdata);
         if (src_valid & src_ready) begin
            out_q.push_back({src_data, src_startofpacket, src_endofpacket});
            if (first_fire < 0) first_fire = cyc;
            last_fire = cyc;
         end
      end
   end

   task automatic do_reset();
      reset_n     = 1'b0;
      cfg_enable  = 1'b0;
      cfg_pkt_len = '0;
      cfg_pattern = 1'b0;
      s_tvalid    = 1'b0;
      src_ready   = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      out_q.delete();
      in_q.delete();
      stim.delete();
      first_fire = -1;
      last_fire  = -1;
      saw_tready = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Drives upstream words from stim and a random sink ready until exp_beats leave the DUT.
   task automatic pump(input int exp_beats, input int ready_pct, input int valid_pct,
                       input int drop_in, input int drop_out, input int budget);
      int n;
      n = 0;
      while (out_q.size() < exp_beats) begin
         if (n >= budget) begin
            vectors++;
            errors++;
            $display("FAIL pump_timeout: got %0d beats, required %0d", out_q.size(), exp_beats);
            break;
         end
         if (drop_in >= 0 && in_q.size() >= drop_in) cfg_enable = 1'b0;
         if (drop_out >= 0 && out_q.size() >= drop_out) cfg_enable = 1'b0;
         if (in_q.size() < stim.size()) begin
            s_tdata  = stim[in_q.size()];
            s_tvalid = ($urandom_range(99) < valid_pct);
         end else begin
            s_tvalid = 1'b0;
         end
         src_ready = ($urandom_range(99) < ready_pct);
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic wait_not_busy();
      int n;
      n = 0;
      src_ready = 1'b1;
      while (busy !== 1'b0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (src_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", src_valid); end
      vectors++; if (src_startofpacket !== 1'b0) begin errors++; $display("FAIL rst_sop: got %b, required 0", src_startofpacket); end
      vectors++; if (src_endofpacket !== 1'b0) begin errors++; $display("FAIL rst_eop: got %b, required 0", src_endofpacket); end
      vectors++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b, required 0", s_tready); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
      vectors++; if (src_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h, required 0", src_data); end
      vectors++; if (pkt_count !== 32'h0) begin errors++; $display("FAIL rst_pkt_count: got %0d, required 0", pkt_count); end
      do_reset();
   endtask

   task automatic test_forward_len4();
      do_reset();
      for (int i = 0; i < 8; i++) stim.push_back(32'h10 + 32'(i));
      cfg_pkt_len = 16'd4;
      cfg_enable  = 1'b1;
      pump(8, 100, 100, 7, -1, 100);
      wait_not_busy();
      for (int k = 0; k < out_q.size(); k++) begin
         vectors++;
         if (out_q[k].data !== stim[k] || out_q[k].sop !== (k % 4 == 0) || out_q[k].eop !== (k % 4 == 3)) begin
            errors++;
            $display("FAIL fwd4_beat%0d: got d=%h sop=%b eop=%b, required d=%h sop=%b eop=%b", k,
                     out_q[k].data, out_q[k].sop, out_q[k].eop, stim[k], k % 4 == 0, k % 4 == 3);
         end
      end
      vectors++; if (last_fire - first_fire !== 7) begin errors++; $display("FAIL fwd4_gapless: got span %0d, required 7", last_fire - first_fire); end
      vectors++; if (pkt_count !== 32'd2) begin errors++; $display("FAIL fwd4_pkt_count: got %0d, required 2", pkt_count); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL fwd4_busy: got %b, required 0", busy); end
   endtask

   task automatic test_pattern_len1();
      do_reset();
      cfg_pattern = 1'b1;
      cfg_pkt_len = 16'd1;
      src_ready   = 1'b1;
      cfg_enable  = 1'b1;
      @(posedge clk); #1;
      vectors++; if (src_valid !== 1'b0) begin errors++; $display("FAIL pat_latency0: got valid %b, required 0", src_valid); end
      @(posedge clk); #1;
      vectors++; if (src_valid !== 1'b1) begin errors++; $display("FAIL pat_latency1: got valid %b, required 1", src_valid); end
      @(posedge clk); #1;
      cfg_enable = 1'b0;
      wait_not_busy();
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (out_q.size() !== 3) begin errors++; $display("FAIL pat_beats: got %0d, required 3", out_q.size()); end
      for (int k = 0; k < out_q.size(); k++) begin
         vectors++;
         if (out_q[k].data !== 32'(k) || out_q[k].sop !== 1'b1 || out_q[k].eop !== 1'b1) begin
            errors++;
            $display("FAIL pat_beat%0d: got d=%h sop=%b eop=%b, required d=%h sop=1 eop=1", k,
                     out_q[k].data, out_q[k].sop, out_q[k].eop, 32'(k));
         end
      end
      vectors++; if (saw_tready !== 1'b0) begin errors++; $display("FAIL pat_tready: got %b, required 0", saw_tready); end
      vectors++; if (pkt_count !== 32'd3) begin errors++; $display("FAIL pat_pkt_count: got %0d, required 3", pkt_count); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL pat_busy: got %b, required 0", busy); end
   endtask

   task automatic test_random_len7();
      do_reset();
      for (int i = 0; i < 70; i++) stim.push_back($urandom);
      cfg_pkt_len = 16'd7;
      cfg_enable  = 1'b1;
      pump(70, 50, 80, 69, -1, 3000);
      wait_not_busy();
      vectors++; if (in_q.size() !== 70) begin errors++; $display("FAIL rnd_in_count: got %0d, required 70", in_q.size()); end
      for (int k = 0; k < out_q.size(); k++) begin
         vectors++;
         if (out_q[k].data !== stim[k] || out_q[k].sop !== (k % 7 == 0) || out_q[k].eop !== (k % 7 == 6)) begin
            errors++;
            $display("FAIL rnd_beat%0d: got d=%h sop=%b eop=%b, required d=%h sop=%b eop=%b", k,
                     out_q[k].data, out_q[k].sop, out_q[k].eop, stim[k], k % 7 == 0, k % 7 == 6);
         end
      end
      vectors++; if (pkt_count !== 32'd10) begin errors++; $display("FAIL rnd_pkt_count: got %0d, required 10", pkt_count); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_busy: got %b, required 0", busy); end
   endtask

   task automatic test_enable_drop();
      do_reset();
      for (int i = 0; i < 16; i++) stim.push_back($urandom);
      cfg_pkt_len = 16'd8;
      cfg_enable  = 1'b1;
      pump(8, 100, 100, -1, 2, 200);
      wait_not_busy();
      s_tvalid = 1'b1;
      s_tdata  = stim[8];
      repeat (10) @(posedge clk);
      #1;
      vectors++; if (out_q.size() !== 8) begin errors++; $display("FAIL drop_out_count: got %0d, required 8", out_q.size()); end
      vectors++; if (in_q.size() !== 8) begin errors++; $display("FAIL drop_in_count: got %0d, required 8", in_q.size()); end
      for (int k = 0; k < out_q.size(); k++) begin
         vectors++;
         if (out_q[k].data !== stim[k] || out_q[k].sop !== (k == 0) || out_q[k].eop !== (k == 7)) begin
            errors++;
            $display("FAIL drop_beat%0d: got d=%h sop=%b eop=%b, required d=%h sop=%b eop=%b", k,
                     out_q[k].data, out_q[k].sop, out_q[k].eop, stim[k], k == 0, k == 7);
         end
      end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy: got %b, required 0", busy); end
      vectors++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL drop_pkt_count: got %0d, required 1", pkt_count); end
      s_tvalid = 1'b0;
   endtask

   task automatic test_len_zero();
      do_reset();
      cfg_pkt_len = 16'd0;
      cfg_enable  = 1'b1;
      s_tvalid    = 1'b1;
      s_tdata     = $urandom;
      src_ready   = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         vectors++; if (src_valid !== 1'b0) begin errors++; $display("FAIL len0_valid: got %b, required 0", src_valid); end
         vectors++; if (s_tready !== 1'b0) begin errors++; $display("FAIL len0_tready: got %b, required 0", s_tready); end
         vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy: got %b, required 0", busy); end
      end
      cfg_enable = 1'b0;
      s_tvalid   = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 10; i++) stim.push_back($urandom);
      cfg_pkt_len = 16'd5;
      cfg_enable  = 1'b1;
      pump(7, 100, 100, -1, -1, 100);
      vectors++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL rmid_pre_pkt_count: got %0d, required 1", pkt_count); end
      vectors++; if (src_valid !== 1'b1 || src_data !== stim[7]) begin errors++; $display("FAIL rmid_beat3: got v=%b d=%h, required v=1 d=%h", src_valid, src_data, stim[7]); end
      #2 reset_n = 1'b0;
      #1;
      vectors++; if (src_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b, required 0", src_valid); end
      vectors++; if (src_endofpacket !== 1'b0) begin errors++; $display("FAIL rmid_eop: got %b, required 0", src_endofpacket); end
      vectors++; if (src_startofpacket !== 1'b0) begin errors++; $display("FAIL rmid_sop: got %b, required 0", src_startofpacket); end
      vectors++; if (src_data !== 32'h0) begin errors++; $display("FAIL rmid_data: got %h, required 0", src_data); end
      vectors++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rmid_tready: got %b, required 0", s_tready); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b, required 0", busy); end
      vectors++; if (pkt_count !== 32'h0) begin errors++; $display("FAIL rmid_pkt_count: got %0d, required 0", pkt_count); end
      do_reset();
      for (int i = 0; i < 5; i++) stim.push_back($urandom);
      cfg_pkt_len = 16'd5;
      cfg_enable  = 1'b1;
      pump(5, 100, 100, 4, -1, 100);
      wait_not_busy();
      for (int k = 0; k < out_q.size(); k++) begin
         vectors++;
         if (out_q[k].data !== stim[k] || out_q[k].sop !== (k == 0) || out_q[k].eop !== (k == 4)) begin
            errors++;
            $display("FAIL rmid_post_beat%0d: got d=%h sop=%b eop=%b, required d=%h sop=%b eop=%b", k,
                     out_q[k].data, out_q[k].sop, out_q[k].eop, stim[k], k == 0, k == 4);
         end
      end
      vectors++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL rmid_post_pkt_count: got %0d, required 1", pkt_count); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_post_busy: got %b, required 0", busy); end
   endtask

   initial begin
      test_reset();
      test_forward_len4();
      test_pattern_len1();
      test_random_len7();
      test_enable_drop();
      test_len_zero();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
